// File: rtl/best_arr_streamer_if.sv
// Bus bundle between the best-array streamer, the best-array RAM read port
// and the write side of the output FIFO.
interface best_arr_streamer_if #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 9
) ();
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_wenq;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_wfull_n;

  // The streamer drives read requests and FIFO writes.
  modport master (
    output mem_ren,
    output mem_raddr,
    input  mem_rdata,
    output out_wenq,
    output out_wdata,
    input  out_wfull_n
  );

  // RAM and FIFO side of the same bundle.
  modport slave (
    input  mem_ren,
    input  mem_raddr,
    output mem_rdata,
    input  out_wenq,
    input  out_wdata,
    output out_wfull_n
  );
endinterface

// File: rtl/best_arr_streamer.sv
// Streams the best-match index array from the best-array RAM into the output
// FIFO, in blocked (partition / block / row / column) or raster order.
// Returned read data lands in a 2-entry skid buffer whose head bypasses the
// register when it is empty, so one word per cycle flows under no backpressure.
module best_arr_streamer #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int NUM_PARTS  = 2,
  parameter int BLOCKING   = 4,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic raster_mode,
  output logic busy,
  output logic done,
  best_arr_streamer_if.master bus
);

  localparam int PART_W  = ROW_SIZE / NUM_PARTS;
  localparam int NUM_BLK = (PART_W + BLOCKING - 1) / BLOCKING;
  localparam int TOTAL   = ROW_SIZE * COL_SIZE;
  localparam int XI_W    = $clog2(BLOCKING + 1);
  localparam int Y_W     = $clog2(COL_SIZE + 1);
  localparam int X_W     = $clog2(NUM_BLK + 1);
  localparam int P_W     = $clog2(NUM_PARTS + 1);

  localparam logic [XI_W-1:0]       XI_LAST = XI_W'(BLOCKING - 1);
  localparam logic [Y_W-1:0]        Y_LAST  = Y_W'(COL_SIZE - 1);
  localparam logic [X_W-1:0]        X_LAST  = X_W'(NUM_BLK - 1);
  localparam logic [P_W-1:0]        P_LAST  = P_W'(NUM_PARTS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ROW   = ADDR_WIDTH'(ROW_SIZE);
  localparam logic [ADDR_WIDTH-1:0] A_BLK   = ADDR_WIDTH'(BLOCKING);
  localparam logic [ADDR_WIDTH-1:0] A_PART  = ADDR_WIDTH'(PART_W);
  localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);

  if (ROW_SIZE % NUM_PARTS != 0) begin : g_param_check
    $error("best_arr_streamer: ROW_SIZE must be a multiple of NUM_PARTS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  raster;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic [ADDR_WIDTH-1:0] xpos;
  logic [ADDR_WIDTH-1:0] part_base;
  logic [ADDR_WIDTH-1:0] col_base;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [XI_W-1:0]       xi;
  logic [Y_W-1:0]        y;
  logic [X_W-1:0]        x;
  logic [P_W-1:0]        p;
  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  issue;
  logic                  last_issue;
  logic                  last_xi;
  logic                  wenq;
  logic                  pop;

  // Read issue: only while running and while buffered plus in-flight words leave room.
  always_comb begin
    issue      = (state == RUN) && ((occ == 2'd0) || ((occ == 2'd1) && !inflight));
    last_issue = (issue_cnt == A_LAST);
    last_xi    = (xi == XI_LAST) || ((xpos + ADDR_WIDTH'(xi) + A_ONE) == A_PART);
  end

  // Output and RAM ports; an empty skid presents the arriving RAM word directly.
  always_comb begin
    wenq          = (occ != 2'd0) || inflight;
    pop           = wenq && bus.out_wfull_n;
    bus.out_wenq  = wenq;
    bus.out_wdata = (occ != 2'd0) ? entry0 : bus.mem_rdata;
    bus.mem_ren   = issue;
    bus.mem_raddr = raster ? issue_cnt : (row_base + ADDR_WIDTH'(xi));
    busy          = (state != IDLE);
  end

  // Skid occupancy after this cycle's arrival and pop.
  always_comb begin
    occ_next = occ;
    case (occ)
      2'd0: occ_next = (inflight && !pop) ? 2'd1 : 2'd0;
      2'd1: begin
        if (pop && !inflight) begin
          occ_next = 2'd0;
        end else if (!pop && inflight) begin
          occ_next = 2'd2;
        end else begin
          occ_next = 2'd1;
        end
      end
      2'd2: occ_next = pop ? 2'd1 : 2'd2;
      default: occ_next = occ;
    endcase
  end

  // Next-state logic; leaving DRAIN waits until every returned word has been written.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (issue && last_issue) next_state = DRAIN;
      DRAIN:   if (occ_next == 2'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == DRAIN) && (next_state == IDLE);
    end
  end

  // Address counters: running bases replace multiplies, invalid tail slots of a block are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raster    <= 1'b0;
      issue_cnt <= '0;
      xi        <= '0;
      y         <= '0;
      x         <= '0;
      p         <= '0;
      xpos      <= '0;
      part_base <= '0;
      col_base  <= '0;
      row_base  <= '0;
    end else if ((state == IDLE) && start) begin
      raster    <= raster_mode;
      issue_cnt <= '0;
      xi        <= '0;
      y         <= '0;
      x         <= '0;
      p         <= '0;
      xpos      <= '0;
      part_base <= '0;
      col_base  <= '0;
      row_base  <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + A_ONE;
      if (!last_xi) begin
        xi <= xi + 1'b1;
      end else begin
        xi <= '0;
        if (y != Y_LAST) begin
          y        <= y + 1'b1;
          row_base <= row_base + A_ROW;
        end else begin
          y <= '0;
          if (x != X_LAST) begin
            x        <= x + 1'b1;
            xpos     <= xpos + A_BLK;
            col_base <= col_base + A_BLK;
            row_base <= col_base + A_BLK;
          end else begin
            x    <= '0;
            xpos <= '0;
            if (p != P_LAST) begin
              p         <= p + 1'b1;
              part_base <= part_base + A_PART;
              col_base  <= part_base + A_PART;
              row_base  <= part_base + A_PART;
            end else begin
              p         <= '0;
              part_base <= '0;
              col_base  <= '0;
              row_base  <= '0;
            end
          end
        end
      end
    end
  end

  // Skid storage: capture RAM data that cannot bypass, shift on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      entry0   <= '0;
      entry1   <= '0;
    end else begin
      inflight <= issue;
      occ      <= occ_next;
      case (occ)
        2'd0: begin
          if (inflight && !pop) entry0 <= bus.mem_rdata;
        end
        2'd1: begin
          if (pop && inflight) begin
            entry0 <= bus.mem_rdata;
          end else if (!pop && inflight) begin
            entry1 <= bus.mem_rdata;
          end
        end
        2'd2: begin
          if (pop) entry0 <= entry1;
        end
        default: begin
          entry0 <= entry0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_best_arr_streamer.sv
// Self-checking bench for best_arr_streamer: default instance plus a
// 24x2 / 3-partition / blocking-8 instance, checked against an order model.
module tb_best_arr_streamer;

  localparam int DW      = 11;
  localparam int AW_A    = 9;
  localparam int AW_B    = 6;
  localparam int TOTAL_A = 494;
  localparam int TOTAL_B = 48;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, raster_a, busy_a, done_a;
  logic start_b, raster_b, busy_b, done_b;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  best_arr_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A)) bus_a ();
  best_arr_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B)) bus_b ();

  best_arr_streamer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .raster_mode(raster_a),
    .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  best_arr_streamer #(
    .DATA_WIDTH(DW), .ROW_SIZE(24), .COL_SIZE(2), .NUM_PARTS(3), .BLOCKING(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .raster_mode(raster_b),
    .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Best-array RAM models preloaded with mem[a] = a, one-cycle read latency.
  logic [DW-1:0] mem_a [TOTAL_A];
  logic [DW-1:0] mem_b [TOTAL_B];
  initial begin
    for (int i = 0; i < TOTAL_A; i++) mem_a[i] = DW'(i);
    for (int i = 0; i < TOTAL_B; i++) mem_b[i] = DW'(i);
  end
  always @(posedge clk) if (bus_a.mem_ren) bus_a.mem_rdata <= mem_a[int'(bus_a.mem_raddr)];
  always @(posedge clk) if (bus_b.mem_ren) bus_b.mem_rdata <= mem_b[int'(bus_b.mem_raddr)];

  // Monitors: only append or count, the directed sequence snapshots and diffs.
  int got_a[$], got_cyc_a[$], got_b[$], got_cyc_b[$];
  int reads_a = 0, done_cnt_a = 0, done_cyc_a = 0, stab_chk_a = 0, stab_err_a = 0, buf_over_a = 0;
  int done_cnt_b = 0, done_cyc_b = 0;
  logic          prev_stall_a = 1'b0;
  logic [DW-1:0] prev_data_a = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      reads_a      = got_a.size();
      prev_stall_a = 1'b0;
    end else begin
      if (bus_a.mem_ren) reads_a++;
      if (bus_a.out_wenq && bus_a.out_wfull_n) begin
        got_a.push_back(int'(bus_a.out_wdata));
        got_cyc_a.push_back(cyc);
      end
      if (reads_a - got_a.size() > 2) buf_over_a++;
      if (prev_stall_a) begin
        stab_chk_a++;
        if (!bus_a.out_wenq || bus_a.out_wdata !== prev_data_a) stab_err_a++;
      end
      prev_stall_a = bus_a.out_wenq && !bus_a.out_wfull_n;
      prev_data_a  = bus_a.out_wdata;
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.out_wenq && bus_b.out_wfull_n) begin
        got_b.push_back(int'(bus_b.out_wdata));
        got_cyc_b.push_back(cyc);
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
    end
  end

  // Results of the most recent run, relative to its start cycle.
  int exp_q[$];
  int res_q[$];
  int res_cyc[$];
  int t0, base, dbase, done_rel, done_seen, stall_hi;
  bit busy_t1, ren_t1, timed_out;

  // Reference order built directly from the nested-loop definition.
  function automatic void build_exp(int row, int col, int parts, int blk, bit raster);
    int part_w;
    int nblk;
    part_w = row / parts;
    nblk   = (part_w + blk - 1) / blk;
    exp_q.delete();
    if (raster) begin
      for (int a = 0; a < row * col; a++) exp_q.push_back(a);
    end else begin
      for (int pp = 0; pp < parts; pp++)
        for (int xx = 0; xx < nblk; xx++)
          for (int yy = 0; yy < col; yy++)
            for (int ii = 0; ii < blk; ii++)
              if (xx * blk + ii < part_w) exp_q.push_back(pp * part_w + yy * row + xx * blk + ii);
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_stream(input string tag);
    check_output({tag, " word count"}, res_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < res_q.size(); i++)
      check_output($sformatf("%s word %0d", tag, i), res_q[i], exp_q[i]);
  endtask

  // One start on the chosen instance; mode 0 = never full, 1 = random full, 2 = 10-cycle stall after first write.
  task automatic apply_stimulus(input int which, input bit raster, input int mode, input int stop_words);
    int  stall_left;
    int  n;
    bit  stall_used;
    logic wf;
    stall_left = 0;
    stall_used = 0;
    n          = 0;
    stall_hi   = 0;
    timed_out  = 0;
    base       = (which == 0) ? got_a.size() : got_b.size();
    dbase      = (which == 0) ? done_cnt_a : done_cnt_b;
    @(posedge clk); #1;
    if (which == 0) begin start_a = 1'b1; raster_a = raster; end
    else begin start_b = 1'b1; raster_b = raster; end
    t0 = cyc;
    bus_a.out_wfull_n = 1'b1;
    bus_b.out_wfull_n = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; raster_a = 1'b0;
    start_b = 1'b0; raster_b = 1'b0;
    busy_t1 = (which == 0) ? busy_a : busy_b;
    ren_t1  = (which == 0) ? bus_a.mem_ren : bus_b.mem_ren;
    while (1) begin
      if (mode == 2 && !stall_used && got_a.size() > base) begin
        stall_used = 1;
        stall_left = 10;
      end
      if (mode == 1) wf = 1'($urandom_range(0, 1));
      else wf = (stall_left == 0);
      bus_a.out_wfull_n = wf;
      bus_b.out_wfull_n = wf;
      @(negedge clk); #1;
      if (stall_left > 0) begin
        if (bus_a.out_wenq) stall_hi++;
        stall_left--;
      end
      if (which == 0 && done_cnt_a > dbase) break;
      if (which == 1 && done_cnt_b > dbase) break;
      if (stop_words > 0 && got_a.size() - base >= stop_words) break;
      n++;
      if (n > 3000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus_a.out_wfull_n = 1'b1;
    bus_b.out_wfull_n = 1'b1;
    res_q.delete();
    res_cyc.delete();
    if (which == 0) begin
      for (int i = base; i < got_a.size(); i++) begin
        res_q.push_back(got_a[i]);
        res_cyc.push_back(got_cyc_a[i] - t0);
      end
      done_seen = done_cnt_a - dbase;
      done_rel  = done_cyc_a - t0;
    end else begin
      for (int i = base; i < got_b.size(); i++) begin
        res_q.push_back(got_b[i]);
        res_cyc.push_back(got_cyc_b[i] - t0);
      end
      done_seen = done_cnt_b - dbase;
      done_rel  = done_cyc_b - t0;
    end
  endtask

  initial begin
    int stab_chk0, stab_err0, over0, dsnap, missing;
    int cnt[TOTAL_A];

    // Reset state.
    rst_n = 1'b0;
    start_a = 1'b0; raster_a = 1'b0; start_b = 1'b0; raster_b = 1'b0;
    bus_a.out_wfull_n = 1'b1;
    bus_b.out_wfull_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy", busy_a, 1'b0);
    check_output("reset done", done_a, 1'b0);
    check_output("reset mem_ren", bus_a.mem_ren, 1'b0);
    check_output("reset out_wenq", bus_a.out_wenq, 1'b0);
    check_output("reset b out_wenq", bus_b.out_wenq, 1'b0);
    rst_n = 1'b1;

    // Blocked order, no backpressure.
    $display("[TB] blocked order, FIFO never full");
    build_exp(26, 19, 2, 4, 1'b0);
    apply_stimulus(0, 1'b0, 0, 0);
    check_output("blk timeout", timed_out, 0);
    check_output("blk busy at T+1", busy_t1, 1'b1);
    check_output("blk mem_ren at T+1", ren_t1, 1'b1);
    check_output("blk first write cycle", res_cyc.size() > 0 ? res_cyc[0] : -1, 2);
    check_output("blk last write cycle", res_cyc.size() > 0 ? res_cyc[res_cyc.size() - 1] : -1, 495);
    check_output("blk done cycle", done_rel, 496);
    check_output("blk done count", done_seen, 1);
    check_output("blk busy after done", busy_a, 1'b0);
    check_output("blk word 0", res_q[0], 0);
    check_output("blk word 3", res_q[3], 3);
    check_output("blk word 4", res_q[4], 26);
    check_output("blk word 76", res_q[76], 4);
    check_output("blk word 228", res_q[228], 12);
    check_output("blk word 229", res_q[229], 38);
    check_output("blk word 247", res_q[247], 13);
    check_stream("blk");

    // Raster order.
    $display("[TB] raster order");
    build_exp(26, 19, 2, 4, 1'b1);
    apply_stimulus(0, 1'b1, 0, 0);
    check_output("raster timeout", timed_out, 0);
    check_output("raster done cycle", done_rel, 496);
    check_stream("raster");

    // Random backpressure, blocked order.
    $display("[TB] blocked order, random FIFO full");
    build_exp(26, 19, 2, 4, 1'b0);
    stab_chk0 = stab_chk_a;
    stab_err0 = stab_err_a;
    over0     = buf_over_a;
    apply_stimulus(0, 1'b0, 1, 0);
    check_output("rand timeout", timed_out, 0);
    check_output("rand done count", done_seen, 1);
    check_output("rand stalls seen", (stab_chk_a - stab_chk0) > 0, 1);
    check_output("rand data held while stalled", stab_err_a - stab_err0, 0);
    check_output("rand buffered over 2", buf_over_a - over0, 0);
    for (int i = 0; i < TOTAL_A; i++) cnt[i] = 0;
    foreach (res_q[i]) if (res_q[i] >= 0 && res_q[i] < TOTAL_A) cnt[res_q[i]]++;
    missing = 0;
    for (int i = 0; i < TOTAL_A; i++) if (cnt[i] != 1) missing++;
    check_output("rand addresses not seen once", missing, 0);
    check_stream("rand");

    // Ten-cycle stall right after the first write.
    $display("[TB] ten-cycle stall after first write");
    over0 = buf_over_a;
    apply_stimulus(0, 1'b0, 2, 0);
    check_output("stall timeout", timed_out, 0);
    check_output("stall wenq held", stall_hi, 10);
    check_output("stall buffered over 2", buf_over_a - over0, 0);
    check_output("stall done cycle", done_rel, 506);
    check_stream("stall");

    // Alternate configuration: 24 wide, 3 partitions, blocking 8, 2 rows.
    $display("[TB] 24x2 config, 3 partitions, blocking 8");
    build_exp(24, 2, 3, 8, 1'b0);
    apply_stimulus(1, 1'b0, 0, 0);
    check_output("cfgb timeout", timed_out, 0);
    check_output("cfgb word 7", res_q[7], 7);
    check_output("cfgb word 8", res_q[8], 24);
    check_output("cfgb word 16", res_q[16], 8);
    check_output("cfgb done cycle", done_rel, 50);
    check_stream("cfgb");

    // Reset in mid-stream, then restart.
    $display("[TB] reset at word 100 then restart");
    build_exp(26, 19, 2, 4, 1'b0);
    apply_stimulus(0, 1'b0, 0, 100);
    check_output("midreset reached word 100", res_q.size() >= 100, 1);
    rst_n = 1'b0;
    #1;
    check_output("midreset busy", busy_a, 1'b0);
    check_output("midreset wenq", bus_a.out_wenq, 1'b0);
    check_output("midreset mem_ren", bus_a.mem_ren, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dsnap = done_cnt_a;
    repeat (20) @(posedge clk);
    #1;
    check_output("midreset no done", done_cnt_a - dsnap, 0);
    apply_stimulus(0, 1'b0, 0, 0);
    check_output("restart timeout", timed_out, 0);
    check_output("restart first word", res_q.size() > 0 ? res_q[0] : -1, 0);
    check_output("restart done cycle", done_rel, 496);
    check_stream("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/best_arr_streamer.md
# best_arr_streamer

Streams the final best-match index array from the on-chip best-array memory into the output FIFO. It runs after the main algorithm asserts done and is triggered by `send_best_arr`. It is a parametrised successor of the fixed readout order: the row split count, blocking factor and image size are parameters, and a raster-order mode is added. It sits between the best-array RAM (synchronous read) and the output FIFO write port (write side of the async FIFO), with full-rate streaming under backpressure.

## Interface
- `DATA_WIDTH`, 11, index word width
- `ROW_SIZE`, 26, query patches per image row
- `COL_SIZE`, 19, query patch rows
- `NUM_PARTS`, 2, vertical row partitions; ROW_SIZE % NUM_PARTS must be 0 (elaboration `$error` otherwise)
- `BLOCKING`, 4, columns per block within a partition
- `ADDR_WIDTH`, $clog2(ROW_SIZE*COL_SIZE), best-array address width (9 at defaults)
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle start pulse (driven from `send_best_arr`)
- `raster_mode`  in  1  0 = blocked order, 1 = raster order; sampled on accepted start
- `busy`  out  1  high from the cycle after start until done
- `done`  out  1  one-cycle pulse after the last word is enqueued
- `mem_ren`  out  1  best-array read enable
- `mem_raddr`  out  ADDR_WIDTH  best-array read address
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_ren`
- `out_wenq`  out  1  output FIFO write enable
- `out_wdata`  out  DATA_WIDTH  output FIFO write data
- `out_wfull_n`  in  1  output FIFO not-full; a write is accepted only when `out_wenq && out_wfull_n`

## Operation
- Reset: all outputs 0, state IDLE, counters 0, skid buffer empty.
- States: IDLE -> RUN on `start` (ignored in RUN/DRAIN); RUN -> DRAIN when the last address is issued; DRAIN -> IDLE when the skid buffer and in-flight read are empty. `done` pulses on the DRAIN -> IDLE transition.
- PART_W = ROW_SIZE/NUM_PARTS, NUM_BLK = ceil(PART_W/BLOCKING), TOTAL = ROW_SIZE*COL_SIZE.
- Blocked order: nested loops p (outer) -> x -> y -> xi (inner). Valid when x*BLOCKING+xi < PART_W; invalid slots are skipped in the same cycle with no bubble. addr = p*PART_W + y*ROW_SIZE + x*BLOCKING + xi.
- Raster order: addr = 0 .. TOTAL-1 incrementing.
- Address generation uses counters only, with no multipliers. Use a running base register: add ROW_SIZE per y step, and add BLOCKING or PART_W at the wrap points.
- Flow control: a 2-entry skid FIFO holds returned data.
  - A read is issued when occupancy + in-flight < 2.
  - `out_wenq` = skid not empty; `out_wdata` = skid head.
  - The head pops on `out_wfull_n`.
- Exactly TOTAL words are enqueued per start, each exactly once, with no duplicates or drops under any `out_wfull_n` pattern.
- Asynchronous reset mid-run returns to IDLE immediately. No `done` is emitted, and the next start restarts from address 0.

## Timing
- Start accepted in cycle T: `busy` is high at T+1 and the first `mem_ren` is at T+1.
- The first `out_wenq` is at T+2 when the FIFO is not full.
- Steady state with `out_wfull_n`=1: one word per cycle and one read per cycle.
  - At defaults, the last `out_wenq` is at T+TOTAL+1 (T+495).
  - `done` is at T+TOTAL+2 and `busy` falls at the same edge.
- `out_wfull_n` low for N cycles stalls output for exactly N cycles. The read pipeline stops within 1 cycle and the skid absorbs the in-flight word.
- `start` in the same cycle as `done` is accepted.

## Test plan
- Default parameters, blocked mode, `out_wfull_n`=1, memory preloaded with mem[a]=a. Required response:
  - words 0..3 = 0,1,2,3; word 4 = 26.
  - word 76 = 4; the x=3 block emits only column 12 (word 228 = 12, word 229 = 38).
  - word 247 = 13.
  - 494 words total; `done` at start+496.
- Raster mode, same preload -> the stream is 0..493 in order, with `done` at start+496.
- Random `out_wfull_n` (50% duty) with blocked mode -> the scoreboard sees each address in 0..493 exactly once and in blocked order; `out_wdata` is held stable while `out_wenq && !out_wfull_n`.
- `out_wfull_n` held low for 10 cycles after the first write -> no write is accepted during the 10 cycles, at most 2 words are buffered, and the stream resumes with no loss.
- Configuration ROW_SIZE=24, NUM_PARTS=3, BLOCKING=8, COL_SIZE=2 -> PART_W=8 with no skipped slots; words 0..7 = 0..7, word 8 = 24, word 16 = 8.
- Reset asserted at word 100, then start re-issued -> no `done` is produced after the reset, and the new stream begins with 0.
